// File: rtl/lsu_axil_master.sv
// Load/store unit: runs one pipeline memory request at a time as an AXI4-Lite
// transaction and returns lane-aligned, extended load data plus an error code.
module lsu_axil_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_err,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_RESP    = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    state_t state, state_next;

    // Captured request, stable until the response handshake.
    logic             we_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic [OFF_W-1:0] off_q;
    logic             owe_q;
    logic [CNT_W-1:0] tmo_cnt;

    logic              accept;
    logic              req_mis;
    logic [OFF_W-1:0]  req_off;
    logic [STRB_W-1:0] strb_base;
    logic              timed_out;
    logic              aw_done;
    logic              w_done;
    logic              drain_beat;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;
    int unsigned           load_bits;
    logic                  load_sign;

    logic                  ar_valid_d;
    logic                  r_ready_d;
    logic                  aw_valid_d;
    logic                  w_valid_d;
    logic                  b_ready_d;
    logic                  rsp_valid_d;
    logic [1:0]            rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;

    assign req_ready  = (state == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign req_off    = req_addr[OFF_W-1:0];
    assign timed_out  = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign aw_done    = !m_awvalid || m_awready;
    assign w_done     = !m_wvalid || m_wready;
    assign drain_beat = we_q ? m_bvalid : m_rvalid;

    always_comb begin
        req_mis   = 1'b0;
        strb_base = '0;
        case (req_size)
            2'd0: begin
                req_mis   = 1'b0;
                strb_base = STRB_W'(1);
            end
            2'd1: begin
                req_mis   = req_addr[0];
                strb_base = STRB_W'(3);
            end
            2'd2: begin
                req_mis   = |req_addr[1:0];
                strb_base = STRB_W'(15);
            end
            default: begin
                // A doubleword cannot travel on a 32-bit bus at all.
                req_mis   = (|req_addr[2:0]) || (DATA_WIDTH == 32);
                strb_base = '1;
            end
        endcase
    end

    // Load lane extraction: move the addressed bytes to bit 0, then extend.
    always_comb begin
        shifted   = m_rdata >> {off_q, 3'b000};
        load_bits = DATA_WIDTH;
        load_sign = 1'b0;
        case (size_q)
            2'd0: begin
                load_bits = 8;
                load_sign = shifted[7];
            end
            2'd1: begin
                load_bits = 16;
                load_sign = shifted[15];
            end
            2'd2: begin
                load_bits = 32;
                load_sign = shifted[31];
            end
            default: begin
                load_bits = DATA_WIDTH;
                load_sign = shifted[DATA_WIDTH-1];
            end
        endcase
        load_sign = load_sign && signed_q;
        load_ext  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            load_ext[i] = (i < int'(load_bits)) ? shifted[i] : load_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_mis)     state_next = S_RESP;
                    else if (req_we) state_next = S_WR_REQ;
                    else             state_next = S_RD_ADDR;
                end
            end
            S_RD_ADDR: if (m_arready)              state_next = S_RD_DATA;
            S_RD_DATA: if (m_rvalid || timed_out)  state_next = S_RESP;
            S_WR_REQ:  if (aw_done && w_done)      state_next = S_WR_RESP;
            S_WR_RESP: if (m_bvalid || timed_out)  state_next = S_RESP;
            S_RESP:    if (rsp_ready)              state_next = owe_q ? S_DRAIN : S_IDLE;
            S_DRAIN:   if (drain_beat)             state_next = S_IDLE;
            default:                               state_next = S_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs.
    always_comb begin
        ar_valid_d  = (state_next == S_RD_ADDR);
        r_ready_d   = (state_next == S_RD_DATA) || ((state_next == S_DRAIN) && !we_q);
        b_ready_d   = (state_next == S_WR_RESP) || ((state_next == S_DRAIN) && we_q);
        aw_valid_d  = 1'b0;
        w_valid_d   = 1'b0;
        if (state_next == S_WR_REQ) begin
            aw_valid_d = (state == S_IDLE) || (m_awvalid && !m_awready);
            w_valid_d  = (state == S_IDLE) || (m_wvalid && !m_wready);
        end
        rsp_valid_d = (state_next == S_RESP);
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        case (state)
            S_IDLE: begin
                if (accept && req_mis) begin
                    rsp_err_d   = ERR_ALIGN;
                    rsp_rdata_d = '0;
                end
            end
            S_RD_DATA: begin
                if (m_rvalid) begin
                    rsp_err_d   = (m_rresp == 2'b00) ? ERR_OK : ERR_BUS;
                    rsp_rdata_d = (m_rresp == 2'b00) ? load_ext : '0;
                end else if (timed_out) begin
                    rsp_err_d   = ERR_TMO;
                    rsp_rdata_d = '0;
                end
            end
            S_WR_RESP: begin
                if (m_bvalid) begin
                    rsp_err_d   = (m_bresp == 2'b00) ? ERR_OK : ERR_BUS;
                    rsp_rdata_d = '0;
                end else if (timed_out) begin
                    rsp_err_d   = ERR_TMO;
                    rsp_rdata_d = '0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_err_d   = ERR_OK;
                    rsp_rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_awaddr  <= '0;
            m_araddr  <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= ERR_OK;
            rsp_rdata <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            signed_q  <= 1'b0;
            off_q     <= '0;
            owe_q     <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            m_arvalid <= ar_valid_d;
            m_rready  <= r_ready_d;
            m_awvalid <= aw_valid_d;
            m_wvalid  <= w_valid_d;
            m_bready  <= b_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                off_q    <= req_off;
                m_awaddr <= req_addr;
                m_araddr <= req_addr;
                m_wdata  <= req_wdata << {req_off, 3'b000};
                m_wstrb  <= strb_base << req_off;
            end
            // A timed-out beat is still owed by the slave and must be swallowed.
            if (((state == S_RD_DATA) && !m_rvalid && timed_out) ||
                ((state == S_WR_RESP) && !m_bvalid && timed_out)) begin
                owe_q <= 1'b1;
            end else if ((state == S_DRAIN) && drain_beat) begin
                owe_q <= 1'b0;
            end
            if ((state == S_RD_DATA) || (state == S_WR_RESP)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed bench for lsu_axil_master: a 32-bit instance (short timeout) and a
// 64-bit instance share request and slave-side stimulus; use64 selects which one is observed.
module tb_lsu_axil_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        use64;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_ready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;

    logic        req_ready_a, rsp_valid_a, awvalid_a, wvalid_a, bready_a, arvalid_a, rready_a;
    logic [31:0] rsp_rdata_a, awaddr_a, araddr_a, wdata_a;
    logic [1:0]  rsp_err_a;
    logic [3:0]  wstrb_a;
    logic        req_ready_b, rsp_valid_b, awvalid_b, wvalid_b, bready_b, arvalid_b, rready_b;
    logic [63:0] rsp_rdata_b, wdata_b;
    logic [31:0] awaddr_b, araddr_b;
    logic [1:0]  rsp_err_b;
    logic [7:0]  wstrb_b;

    logic        x_req_ready, x_rsp_valid, x_awvalid, x_wvalid, x_bready, x_arvalid, x_rready;
    logic [63:0] x_rsp_rdata, x_wdata;
    logic [31:0] x_awaddr, x_araddr;
    logic [1:0]  x_rsp_err;
    logic [7:0]  x_wstrb;

    int          n_checks = 0;
    int          n_errors = 0;
    string       cur = "reset";
    logic [65:0] exp_q[$];

    always #5 clk = ~clk;

    lsu_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !use64), .req_ready(req_ready_a),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .m_awaddr(awaddr_a), .m_awvalid(awvalid_a), .m_awready(awready),
        .m_wdata(wdata_a), .m_wstrb(wstrb_a), .m_wvalid(wvalid_a), .m_wready(wready),
        .m_bresp(bresp), .m_bvalid(bvalid), .m_bready(bready_a),
        .m_araddr(araddr_a), .m_arvalid(arvalid_a), .m_arready(arready),
        .m_rdata(rdata[31:0]), .m_rresp(rresp), .m_rvalid(rvalid), .m_rready(rready_a)
    );

    lsu_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(256)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && use64), .req_ready(req_ready_b),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .m_awaddr(awaddr_b), .m_awvalid(awvalid_b), .m_awready(awready),
        .m_wdata(wdata_b), .m_wstrb(wstrb_b), .m_wvalid(wvalid_b), .m_wready(wready),
        .m_bresp(bresp), .m_bvalid(bvalid), .m_bready(bready_b),
        .m_araddr(araddr_b), .m_arvalid(arvalid_b), .m_arready(arready),
        .m_rdata(rdata), .m_rresp(rresp), .m_rvalid(rvalid), .m_rready(rready_b)
    );

    assign x_req_ready = use64 ? req_ready_b : req_ready_a;
    assign x_rsp_valid = use64 ? rsp_valid_b : rsp_valid_a;
    assign x_awvalid   = use64 ? awvalid_b   : awvalid_a;
    assign x_wvalid    = use64 ? wvalid_b    : wvalid_a;
    assign x_bready    = use64 ? bready_b    : bready_a;
    assign x_arvalid   = use64 ? arvalid_b   : arvalid_a;
    assign x_rready    = use64 ? rready_b    : rready_a;
    assign x_rsp_rdata = use64 ? rsp_rdata_b : {32'h0, rsp_rdata_a};
    assign x_wdata     = use64 ? wdata_b     : {32'h0, wdata_a};
    assign x_awaddr    = use64 ? awaddr_b    : awaddr_a;
    assign x_araddr    = use64 ? araddr_b    : araddr_a;
    assign x_rsp_err   = use64 ? rsp_err_b   : rsp_err_a;
    assign x_wstrb     = use64 ? wstrb_b     : {4'h0, wstrb_a};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %h expected %h", cur, tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [63:0] wd);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        check("req_ready", 64'(x_req_ready), 64'd1);
        tick();
        req_valid  = 1'b0;
    endtask

    // Response must be visible now; optionally stall it, then complete the handshake.
    task automatic wait_rsp(input int stall);
        logic [65:0] e;
        check("exp_q_size", 64'(exp_q.size()), 64'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 66'h0;
        check("rsp_valid", 64'(x_rsp_valid), 64'd1);
        check("rsp_rdata", x_rsp_rdata, e[63:0]);
        check("rsp_err", 64'(x_rsp_err), 64'(e[65:64]));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 64'(x_rsp_valid), 64'd1);
            check("stall_rdata", x_rsp_rdata, e[63:0]);
            check("stall_err", 64'(x_rsp_err), 64'(e[65:64]));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done", 64'(x_rsp_valid), 64'd0);
        check("idle_ready", 64'(x_req_ready), 64'd1);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [63:0] rd, input logic [1:0] rr,
                           input logic [63:0] exp_d, input logic [1:0] exp_e, input int stall);
        cur = tag;
        arready = 1'b1;
        exp_q.push_back({exp_e, exp_d});
        send_req(1'b0, size, sgn, addr, 64'h0);
        check("arvalid", 64'(x_arvalid), 64'd1);
        check("araddr", 64'(x_araddr), 64'(addr));
        check("early_rsp", 64'(x_rsp_valid), 64'd0);
        tick();
        check("rready", 64'(x_rready), 64'd1);
        check("arvalid_drop", 64'(x_arvalid), 64'd0);
        rvalid = 1'b1;
        rdata  = rd;
        rresp  = rr;
        tick();
        rvalid = 1'b0;
        check("rready_drop", 64'(x_rready), 64'd0);
        wait_rsp(stall);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [63:0] wd, input logic [63:0] exp_wd,
                            input logic [7:0] exp_strb, input int aw_dly, input int w_dly,
                            input logic [1:0] br, input logic [1:0] exp_e);
        int n;
        cur = tag;
        awready = 1'b0;
        wready  = 1'b0;
        exp_q.push_back({exp_e, 64'h0});
        send_req(1'b1, size, 1'b0, addr, wd);
        check("awaddr", 64'(x_awaddr), 64'(addr));
        check("wdata", x_wdata, exp_wd);
        check("wstrb", 64'(x_wstrb), 64'(exp_strb));
        n = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int k = 0; k <= n; k++) begin
            check("awvalid", 64'(x_awvalid), 64'(k <= aw_dly));
            check("wvalid", 64'(x_wvalid), 64'(k <= w_dly));
            awready = (k == aw_dly);
            wready  = (k == w_dly);
            tick();
        end
        awready = 1'b0;
        wready  = 1'b0;
        check("aw_done", 64'(x_awvalid), 64'd0);
        check("w_done", 64'(x_wvalid), 64'd0);
        check("bready", 64'(x_bready), 64'd1);
        bvalid = 1'b1;
        bresp  = br;
        tick();
        bvalid = 1'b0;
        check("bready_drop", 64'(x_bready), 64'd0);
        wait_rsp(0);
    endtask

    task automatic do_misaligned(input string tag, input logic we, input logic [1:0] size,
                                 input logic [31:0] addr);
        cur = tag;
        exp_q.push_back({2'b01, 64'h0});
        send_req(we, size, 1'b1, addr, 64'hFFFF_FFFF_FFFF_FFFF);
        check("no_ar", 64'(x_arvalid), 64'd0);
        check("no_aw", 64'(x_awvalid), 64'd0);
        check("no_w", 64'(x_wvalid), 64'd0);
        wait_rsp(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;   use64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            use64 = (s == 1);
            #1;
            check("req_ready", 64'(x_req_ready), 64'd1);
            check("rsp_valid", 64'(x_rsp_valid), 64'd0);
            check("rsp_rdata", x_rsp_rdata, 64'h0);
            check("rsp_err", 64'(x_rsp_err), 64'h0);
            check("valids", 64'({x_arvalid, x_awvalid, x_wvalid, x_rready, x_bready}), 64'h0);
        end
        use64 = 1'b0;
        rst = 1'b0;
        tick();

        // 32-bit bus
        do_load("lb_s",  32'h8000_0003, 2'd0, 1'b1, 64'h80AB_CDEF, 2'b00, 64'hFFFF_FF80, 2'b00, 0);
        do_load("lb_u",  32'h8000_0003, 2'd0, 1'b0, 64'h80AB_CDEF, 2'b00, 64'h0000_0080, 2'b00, 0);
        do_load("lh_s",  32'h8000_0002, 2'd1, 1'b1, 64'h80AB_CDEF, 2'b00, 64'hFFFF_80AB, 2'b00, 0);
        do_load("lh_u",  32'h8000_0000, 2'd1, 1'b0, 64'h80AB_CDEF, 2'b00, 64'h0000_CDEF, 2'b00, 0);
        do_load("lb_s1", 32'h8000_0001, 2'd0, 1'b1, 64'h1234_5678, 2'b00, 64'h0000_0056, 2'b00, 0);
        do_load("lw",    32'h8000_0004, 2'd2, 1'b1, 64'h80AB_CDEF, 2'b00, 64'h80AB_CDEF, 2'b00, 5);
        do_load("decerr", 32'h8000_0008, 2'd2, 1'b0, 64'h1234_5678, 2'b11, 64'h0, 2'b10, 0);
        do_store("sh",   32'h8000_0002, 2'd1, 64'h1234, 64'h1234_0000, 8'b1100, 3, 0, 2'b00, 2'b00);
        do_store("sb_slverr", 32'h8000_0001, 2'd0, 64'hAB, 64'h0000_AB00, 8'b0010, 0, 0, 2'b10, 2'b10);
        do_store("sw",   32'h8000_0000, 2'd2, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 8'b1111, 0, 2, 2'b00, 2'b00);
        do_misaligned("lw_mis", 1'b0, 2'd2, 32'h8000_0006);
        do_misaligned("sh_mis", 1'b1, 2'd1, 32'h8000_0001);
        do_misaligned("sd_on32", 1'b1, 2'd3, 32'h8000_0000);

        // Slave never answers: timeout after 8 cycles, then drain the late beat.
        cur = "timeout";
        arready = 1'b1;
        send_req(1'b0, 2'd2, 1'b0, 32'h8000_0040, 64'h0);
        check("arvalid", 64'(x_arvalid), 64'd1);
        for (int c = 1; c < 10; c++) begin
            check("no_rsp_yet", 64'(x_rsp_valid), 64'd0);
            tick();
        end
        check("rsp_valid", 64'(x_rsp_valid), 64'd1);
        check("rsp_err", 64'(x_rsp_err), 64'h3);
        check("rsp_rdata", x_rsp_rdata, 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("drain_rready", 64'(x_rready), 64'd1);
        for (int c = 11; c < 20; c++) begin
            check("drain_busy", 64'(x_req_ready), 64'd0);
            tick();
        end
        check("drain_busy20", 64'(x_req_ready), 64'd0);
        rvalid = 1'b1;
        rdata  = 64'h5555_5555;
        tick();
        rvalid = 1'b0;
        check("drain_idle", 64'(x_req_ready), 64'd1);
        check("drain_rready_drop", 64'(x_rready), 64'd0);
        check("drain_no_rsp", 64'(x_rsp_valid), 64'd0);
        do_load("after_drain", 32'h8000_0010, 2'd2, 1'b0, 64'h0BAD_F00D, 2'b00, 64'h0BAD_F00D, 2'b00, 0);

        // 64-bit bus
        use64 = 1'b1;
        #1;
        do_load("ld_s",  32'h8000_0008, 2'd3, 1'b1, 64'hFEDC_BA98_7654_3210, 2'b00,
                64'hFEDC_BA98_7654_3210, 2'b00, 5);
        do_load("lw_s64", 32'h8000_0004, 2'd2, 1'b1, 64'h8000_0001_0000_0000, 2'b00,
                64'hFFFF_FFFF_8000_0001, 2'b00, 0);
        do_load("lbu_64", 32'h8000_0007, 2'd0, 1'b0, 64'hAB00_0000_0000_0000, 2'b00,
                64'h0000_0000_0000_00AB, 2'b00, 0);
        do_store("sw_64", 32'h8000_0004, 2'd2, 64'h1122_3344, 64'h1122_3344_0000_0000,
                 8'hF0, 0, 0, 2'b00, 2'b00);
        do_store("sd_64", 32'h8000_0008, 2'd3, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708,
                 8'hFF, 1, 0, 2'b00, 2'b00);
        do_misaligned("ld_mis", 1'b0, 2'd3, 32'h8000_0004);

        // Reset while AW/W are both pending.
        cur = "rst_mid";
        awready = 1'b0;
        wready  = 1'b0;
        send_req(1'b1, 2'd2, 1'b0, 32'h8000_0000, 64'h1);
        check("awvalid", 64'(x_awvalid), 64'd1);
        check("wvalid", 64'(x_wvalid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("valids", 64'({x_awvalid, x_wvalid, x_bready, x_arvalid, x_rready}), 64'h0);
        check("rsp_valid", 64'(x_rsp_valid), 64'd0);
        check("req_ready", 64'(x_req_ready), 64'd1);
        tick();
        tick();
        check("rsp_valid_later", 64'(x_rsp_valid), 64'd0);
        check("aw_stays_low", 64'(x_awvalid), 64'd0);
        do_load("after_rst", 32'h8000_0000, 2'd1, 1'b1, 64'h0000_0000_0000_8001, 2'b00,
                64'hFFFF_FFFF_FFFF_8001, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
